// File: rtl/div_ctrl_pkg.sv
// Shared mul/div package: FSM state encoding, default widths and the
// iteration count the external divider core needs per operation.
package div_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
    localparam int ITER      = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT,
        FIX
    } state_t;

endpackage

// File: rtl/div_ctrl_sign_fix.sv
// sign_fix: conditional two's-complement negation.
// Used both to turn signed operands into unsigned magnitudes for the core
// and to restore the sign of the core's quotient/remainder.
//   neg : 1 = negate val, 0 = pass val through
//   val : input value
//   res : val or -val (the most negative value maps onto itself)
module sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = neg ? (~val + WIDTH'(1)) : val;
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer around an external iterative divider core.
// Handles divide-by-zero, signed/unsigned operand conditioning, core launch,
// result sign correction and a watchdog on the core's progress counter.
//   clk, reset          : clock, synchronous active-high reset
//   start, is_signed    : request pulse (IDLE only) and signedness
//   A, B                : dividend / divisor, sampled with start
//   LO, HI              : registered quotient / remainder
//   busy, done          : operation in flight / one-cycle completion pulse
//   div0, timeout       : divide-by-zero and watchdog flags
//   core_A, core_B      : unsigned magnitudes to the core
//   core_reset          : one-cycle launch strobe to the core
//   core_LO, core_HI    : core quotient / remainder
//   core_counter        : core iteration progress
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO   = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             timeout,
    output logic [WIDTH-1:0] core_A,
    output logic [WIDTH-1:0] core_B,
    output logic             core_reset,
    input  logic [WIDTH-1:0] core_LO,
    input  logic [WIDTH-1:0] core_HI,
    input  logic [CNT_W-1:0] core_counter
);

    localparam int WD_W = $clog2(TMO + 2);

    state_t            state;
    logic              sgn;       // latched is_signed
    logic              sa;        // latched sign bit of A
    logic              sb;        // latched sign bit of B
    logic              hit;       // core_counter reached ITER last cycle
    logic [WD_W-1:0]   wd;        // cycles spent in RUN
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH-1:0]  fix_q;
    logic [WIDTH-1:0]  fix_r;

    // Operand conditioning
    sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .neg (is_signed & A[WIDTH-1]),
        .val (A),
        .res (mag_a)
    );

    sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .neg (is_signed & B[WIDTH-1]),
        .val (B),
        .res (mag_b)
    );

    // Result correction: quotient sign is sign(A)^sign(B), remainder
    // follows the dividend.
    sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .neg (sgn & (sa ^ sb)),
        .val (core_LO),
        .res (fix_q)
    );

    sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .neg (sgn & sa),
        .val (core_HI),
        .res (fix_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            LO         <= '0;
            HI         <= '0;
            core_A     <= '0;
            core_B     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div0       <= 1'b0;
            timeout    <= 1'b0;
            core_reset <= 1'b0;
            sgn        <= 1'b0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            hit        <= 1'b0;
            wd         <= '0;
        end else begin
            done       <= 1'b0;
            core_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout <= 1'b0;
                        if (B == '0) begin
                            // Answered immediately without touching the core.
                            div0 <= 1'b1;
                            LO   <= '1;
                            HI   <= A;
                            done <= 1'b1;
                        end else begin
                            div0       <= 1'b0;
                            sgn        <= is_signed;
                            sa         <= A[WIDTH-1];
                            sb         <= B[WIDTH-1];
                            core_A     <= mag_a;
                            core_B     <= mag_b;
                            core_reset <= 1'b1;
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    hit   <= 1'b0;
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // Completion is seen one cycle after the counter hits
                    // ITER; it takes priority over the watchdog.
                    if (hit) begin
                        state <= WAIT;
                    end else if (wd >= WD_W'(TMO)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        hit <= (core_counter == CNT_W'(ITER));
                        wd  <= wd + WD_W'(1);
                    end
                end
                WAIT: begin
                    // core_LO/core_HI have settled; capture corrected results
                    // so done is high during FIX.
                    LO    <= fix_q;
                    HI    <= fix_r;
                    done  <= 1'b1;
                    state <= FIX;
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider core and a
// scoreboard queue of expected results.
module tb_div_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] LO, HI, core_A, core_B;
    logic        busy, done, div0, timeout, core_reset;
    logic [31:0] core_LO = '0;
    logic [31:0] core_HI = '0;
    logic [5:0]  core_counter = '0;
    bit          stuck = 1'b0;
    bit          running = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        d0;
        logic        to;
        int          lat;
        logic [31:0] ma;
        logic [31:0] mb;
    } exp_t;

    exp_t sb[$];

    div_ctrl #(.WIDTH(32), .CNT_W(6), .TMO(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .A            (A),
        .B            (B),
        .LO           (LO),
        .HI           (HI),
        .busy         (busy),
        .done         (done),
        .div0         (div0),
        .timeout      (timeout),
        .core_A       (core_A),
        .core_B       (core_B),
        .core_reset   (core_reset),
        .core_LO      (core_LO),
        .core_HI      (core_HI),
        .core_counter (core_counter)
    );

    always #5 clk = ~clk;

    // Behavioural core: counter restarts on core_reset, climbs to 32, and
    // results appear on the same edge the counter reaches 32.
    always @(posedge clk) begin
        if (core_reset) begin
            core_counter <= '0;
            running      <= 1'b1;
        end else if (stuck) begin
            core_counter <= 6'd5;
        end else if (running && core_counter < 6'd32) begin
            core_counter <= core_counter + 6'd1;
            if (core_counter == 6'd31 && core_B != 0) begin
                core_LO <= core_A / core_B;
                core_HI <= core_A % core_B;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        exp_t e;
        e.d0  = 1'b0;
        e.to  = 1'b0;
        e.lat = 36;
        e.ma  = (sg && a[31]) ? (32'd0 - a) : a;
        e.mb  = (sg && b[31]) ? (32'd0 - b) : b;
        if (b == 0) begin
            e.lo  = 32'hFFFF_FFFF;
            e.hi  = a;
            e.d0  = 1'b1;
            e.lat = 0;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'h0;
            end else begin
                e.lo = 32'($signed(a) / $signed(b));
                e.hi = 32'($signed(a) % $signed(b));
            end
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input bit tmo_case);
        exp_t e;
        exp_t got;
        int   lat;
        int   cr;
        int   unstable;
        bit   busy_seen;
        e = model(a, b, sg);
        if (tmo_case) begin
            e.lo  = last_lo;
            e.hi  = last_hi;
            e.to  = 1'b1;
            e.lat = TMO + 2;
        end
        sb.push_back(e);
        A = a;
        B = b;
        is_signed = sg;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        cr = 0;
        unstable = 0;
        busy_seen = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            busy_seen = busy_seen | (busy === 1'b1);
            if (core_reset === 1'b1) cr++;
            if (busy === 1'b1 && (core_A !== e.ma || core_B !== e.mb)) unstable++;
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        chk({tag, ".latency"}, 32'(lat), 32'(got.lat));
        chk({tag, ".LO"}, LO, got.lo);
        chk({tag, ".HI"}, HI, got.hi);
        chk({tag, ".div0"}, {31'b0, div0}, {31'b0, got.d0});
        chk({tag, ".timeout"}, {31'b0, timeout}, {31'b0, got.to});
        if (got.d0) begin
            chk({tag, ".busy_seen"}, {31'b0, busy_seen}, 32'd0);
        end else begin
            chk({tag, ".core_reset_cycles"}, 32'(cr), 32'd1);
            chk({tag, ".core_operands_stable"}, 32'(unstable), 32'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse_width"}, {31'b0, done}, 32'd0);
        last_lo = got.lo;
        last_hi = got.hi;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          done_cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.LO", LO, 32'd0);
        chk("rst.HI", HI, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.flags", {30'b0, div0, timeout}, 32'd0);
        chk("rst.core_A", core_A, 32'd0);
        chk("rst.core_reset", {31'b0, core_reset}, 32'd0);

        // Directed operations
        run_op("u100div7", 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold.LO", LO, 32'd14);
        chk("hold.HI", HI, 32'd2);
        run_op("s_m7div2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_op("div0", 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_op("s_min_div_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("s_7div_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("s_m100div_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0);
        run_op("u_big", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            run_op("random", ra, rb, rs, 1'b0);
        end

        // Second start ignored while busy, then reset mid-RUN
        A = 32'd500;
        B = 32'd9;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) begin
                A = 32'd77;
                B = 32'd3;
                start = 1'b1;
            end
            if (k == 11) start = 1'b0;
            if (k == 15) chk("ignored_start.core_A", core_A, 32'd500);
            if (k == 20) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        chk("midrst.LO", LO, 32'd0);
        chk("midrst.HI", HI, 32'd0);
        chk("midrst.status", {28'b0, busy, done, div0, timeout}, 32'd0);
        chk("midrst.core", core_A | core_B | {31'b0, core_reset}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        chk("midrst.no_done", 32'(done_cnt), 32'd0);
        last_lo = '0;
        last_hi = '0;

        // Watchdog with a stuck core; LO/HI keep the previous result
        run_op("pre_tmo", 32'd1000, 32'd3, 1'b0, 1'b0);
        stuck = 1'b1;
        run_op("tmo", 32'd50, 32'd5, 1'b0, 1'b1);
        stuck = 1'b0;
        run_op("post_tmo", 32'd81, 32'd9, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter CNT_W, default 6, width of the core iteration counter.
REQ-003 SHALL have parameter TMO, default 40, watchdog limit in cycles after core launch.
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request pulse, sampled only in IDLE.
REQ-007 SHALL have port is_signed  in  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 SHALL have ports A, B  in  WIDTH  dividend and divisor, sampled with start.
REQ-009 SHALL have ports LO, HI  out  WIDTH  registered quotient and remainder.
REQ-010 SHALL have ports busy, done, div0, timeout  out  1  status; done is a one-cycle pulse.
REQ-011 SHALL have ports core_A, core_B  out  WIDTH  unsigned magnitudes driven to the divider core.
REQ-012 SHALL have port core_reset  out  1  active-high launch strobe to the core.
REQ-013 SHALL have ports core_LO, core_HI  in  WIDTH, and core_counter  in  CNT_W  core results and progress.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, WAIT, FIX.
REQ-015 IDLE: start=1 with B=0 SHALL set div0=1, LO=all ones, HI=A, pulse done next cycle, and stay in IDLE.
REQ-016 IDLE: start=1 with B!=0 SHALL latch is_signed, sign(A), and sign(B), clear div0 and timeout, drive core_A/core_B, and go to LOAD.
REQ-017 Magnitudes: when signed and the operand is negative, the driven value SHALL be its two's-complement negation; otherwise it SHALL be the raw value. 0x80000000 SHALL map to 0x80000000.
REQ-018 LOAD SHALL hold core_reset=1 for exactly one cycle, then go to RUN; core_reset SHALL be 0 in all other states.
REQ-019 RUN SHALL go to WAIT in the cycle after core_counter==32 is sampled.
REQ-020 WAIT SHALL last exactly one cycle so core_LO/core_HI settle, then go to FIX.
REQ-021 FIX result rules, applied to core_LO/core_HI:
 - LO SHALL be the negated quotient when signed and sign(A)^sign(B), else the quotient.
 - HI SHALL be the negated remainder when signed and sign(A), else the remainder.
 - done SHALL pulse for 1 cycle, then the FSM SHALL return to IDLE.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, with no flag raised.
REQ-023 busy SHALL be 1 in LOAD, RUN, WAIT, and FIX, and 0 in IDLE.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 Watchdog: if RUN lasts more than TMO cycles, the block SHALL set timeout=1, pulse done, leave LO/HI unchanged, and return to IDLE.
REQ-026 core_A/core_B SHALL stay stable from LOAD until the return to IDLE.
REQ-027 Nominal latency with a conforming core SHALL be 36 cycles, measured from the start-sampling edge to the done pulse.
REQ-028 LO, HI, div0, and timeout SHALL hold their values until the next accepted start.

Reset
REQ-029 reset=1 SHALL force IDLE and clear LO, HI, core_A, core_B, busy, done, div0, timeout, and core_reset to 0 on the next edge.
REQ-030 reset SHALL override start and any in-flight operation; a mid-RUN reset SHALL discard the result and produce no done.

Structure
REQ-031 The FSM state enum, WIDTH/CNT_W defaults, and ITER=32 constant SHALL live in a shared muldiv package.
REQ-032 Sign and magnitude logic SHALL be one sub-module, sign_fix, instantiated for operand conditioning and result correction.
REQ-033 The divider core SHALL be external; div_ctrl SHALL contain no iterative divide datapath.

Verification
REQ-034 Unsigned A=100, B=7 SHALL give LO=14, HI=2, done at cycle 36, div0=0.
REQ-035 Signed A=0xFFFFFFF9 (-7), B=2 SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 B=0, A=0x1234 SHALL give div0=1, LO=0xFFFFFFFF, HI=0x1234, done 1 cycle after start, busy never 1.
REQ-037 Signed A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-038 A second start at cycle 10 SHALL be ignored; a reset at cycle 20 SHALL give IDLE with all outputs 0 and no done.
REQ-039 A core model with counter stuck at 5 SHALL give timeout=1 with done on cycle TMO+2 after start, and LO/HI unchanged.
